uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_defs_pkg.sv | 6 +
 rtl/uart_baud_tick.sv | 17 +
 rtl/uart_rx.sv | 106 ++++++++++
 tb/tb_uart_rx.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/uart_defs_pkg.sv
// uart_defs_pkg: UART constants and receiver state encoding shared by transmitter and receiver
package uart_defs_pkg;
  localparam int OS_DEF = 16;
  localparam int CLKS_PER_TICK_DEF = 429;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16x oversample tick generator; clk, rst (sync active-low), clr (restart count), tick (1-clock pulse)
module uart_baud_tick #(
  parameter int CLKS_PER_TICK = uart_defs_pkg::CLKS_PER_TICK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_TICK + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == W'(CLKS_PER_TICK - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
  end
  always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver; serial_in -> parallel_out with rx_valid/frame_err pulses, busy outside IDLE, sync active-low rst, rx_en gate
module uart_rx
  import uart_defs_pkg::*;
#(
  parameter int CLKS_PER_TICK = CLKS_PER_TICK_DEF,
  parameter int OVERSAMPLE = OS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       serial_in,
  output logic [7:0] parallel_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] OS_MID = 4'(OVERSAMPLE / 2 - 1);
  rx_state_e state_q, state_d;
  logic [3:0] os_q, os_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, out_q, out_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic s1_q, rx_s_q, rx_d_q;
  logic tick, clr;
  uart_baud_tick #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .clk(clk), .rst(rst), .clr(clr), .tick(tick)
  );
  always_comb begin
    state_d = state_q;
    os_d = os_q;
    idx_d = idx_q;
    shift_d = shift_q;
    out_d = out_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    clr = 1'b0;
    if (!rx_en) begin
      state_d = IDLE;
      os_d = '0;
      idx_d = '0;
    end else begin
      case (state_q)
        IDLE: if (rx_d_q && !rx_s_q) begin
          state_d = START;
          clr = 1'b1;
          os_d = '0;
        end
        START: if (tick) begin
          if (os_q == OS_MID) begin
            // a start bit that is high again at mid-bit is a glitch, not a frame
            state_d = rx_s_q ? IDLE : DATA;
            os_d = '0;
            idx_d = '0;
          end else os_d = os_q + 4'd1;
        end
        DATA: if (tick) begin
          if (os_q == OS_LAST) begin
            shift_d[idx_q] = rx_s_q;
            os_d = '0;
            idx_d = idx_q + 3'd1;
            state_d = idx_q == 3'd7 ? STOP : DATA;
          end else os_d = os_q + 4'd1;
        end
        STOP: if (tick) begin
          if (os_q == OS_LAST) begin
            out_d = rx_s_q ? shift_q : out_q;
            valid_d = rx_s_q;
            ferr_d = !rx_s_q;
            state_d = IDLE;
          end else os_d = os_q + 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      os_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      out_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      s1_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      state_q <= state_d;
      os_q <= os_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      out_q <= out_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      s1_q <= serial_in;
      rx_s_q <= s1_q;
      rx_d_q <= rx_s_q;
    end
  end
  assign parallel_out = out_q;
  assign rx_valid = valid_q;
  assign frame_err = ferr_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-frame bench for uart_rx
module tb_uart_rx;
  localparam int CPT = 4;
  localparam int BITC = 16 * CPT;
  logic clk = 1'b0, rst = 1'b0, rx_en = 1'b1, serial_in = 1'b1;
  logic [7:0] parallel_out;
  logic rx_valid, frame_err, busy;
  int n_vec = 0, n_bad = 0;
  int cyc = 0, nv = 0, nf = 0, ovl = 0, wide = 0, last_t = 0, prev_t = 0;
  logic pv = 1'b0, pf = 1'b0;
  logic [7:0] got_q[$];
  int base;

  uart_rx #(.CLKS_PER_TICK(CPT)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .serial_in(serial_in),
    .parallel_out(parallel_out), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (rx_valid) begin
      nv++;
      got_q.push_back(parallel_out);
      prev_t = last_t;
      last_t = cyc;
    end
    if (frame_err) nf++;
    if (rx_valid && frame_err) ovl++;
    if ((rx_valid && pv) || (frame_err && pf)) wide++;
    pv = rx_valid;
    pf = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic line(input logic v, input int clocks);
    serial_in = v;
    repeat (clocks) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] b, input logic stop);
    line(1'b0, BITC);
    for (int i = 0; i < 8; i++) line(b[i], BITC);
    line(stop, BITC);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_out", parallel_out, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    line(1'b1, 2 * BITC);
    frame(8'h75, 1'b1);
    line(1'b1, BITC);
    frame(8'h33, 1'b1);
    line(1'b1, BITC);
    frame(8'h79, 1'b1);
    line(1'b1, 2 * BITC);
    chk("three_valid", nv, 3);
    chk("byte0", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h75);
    chk("byte1", got_q.size() > 1 ? got_q[1] : 8'hxx, 8'h33);
    chk("byte2", got_q.size() > 2 ? got_q[2] : 8'hxx, 8'h79);
    chk("no_ferr", nf, 0);
    // glitch: start low for 4 ticks only
    line(1'b0, 4 * CPT);
    chk("glitch_busy", busy, 1'b1);
    line(1'b1, 4 * CPT + 8);
    chk("glitch_idle", busy, 1'b0);
    line(1'b1, 2 * BITC);
    chk("glitch_novalid", nv, 3);
    // 0xA5 with stop low, line held low afterwards
    frame(8'hA5, 1'b0);
    line(1'b0, 3 * BITC);
    chk("ferr_pulse", nf, 1);
    chk("ferr_novalid", nv, 3);
    chk("ferr_hold", parallel_out, 8'h79);
    chk("break_idle", busy, 1'b0);
    line(1'b1, 2 * BITC);
    chk("break_norestart", busy, 1'b0);
    // back-to-back with zero gap
    frame(8'h00, 1'b1);
    frame(8'hFF, 1'b1);
    line(1'b1, 2 * BITC);
    chk("b2b_valid", nv, 5);
    chk("b2b_byte0", got_q.size() > 3 ? got_q[3] : 8'hxx, 8'h00);
    chk("b2b_byte1", got_q.size() > 4 ? got_q[4] : 8'hxx, 8'hFF);
    chk("b2b_spacing", last_t - prev_t, 160 * CPT);
    // reset during bit 3 of 0x5A
    line(1'b0, BITC);
    line(1'b0, BITC);
    line(1'b1, BITC);
    line(1'b0, BITC);
    line(1'b1, BITC / 2);
    rst = 1'b0;
    line(1'b1, 4);
    chk("midrst_out", parallel_out, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b1;
    line(1'b1, 12 * BITC);
    chk("midrst_nopulse", nv + nf, 6);
    frame(8'h3C, 1'b1);
    line(1'b1, 2 * BITC);
    chk("post_rst_valid", nv, 6);
    chk("post_rst_out", parallel_out, 8'h3C);
    // receiver disabled for a whole frame
    rx_en = 1'b0;
    frame(8'h96, 1'b1);
    line(1'b1, 2 * BITC);
    chk("dis_nopulse", nv + nf, 7);
    chk("dis_busy", busy, 1'b0);
    // enable dropped mid-frame
    rx_en = 1'b1;
    line(1'b1, BITC);
    line(1'b0, BITC);
    for (int i = 0; i < 4; i++) line(i == 0, BITC);
    chk("abort_busy_pre", busy, 1'b1);
    rx_en = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    rx_en = 1'b1;
    for (int i = 4; i < 8; i++) line(1'b1, BITC);
    line(1'b1, 3 * BITC);
    chk("abort_nopulse", nv + nf, 7);
    chk("abort_hold", parallel_out, 8'h3C);
    chk("never_overlap", ovl, 0);
    chk("pulse_width", wide, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
